// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding, sample-edge helper
// and default word width / synchroniser depth.
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_e;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;

    // Modes 0/3 sample on rising SCLK, modes 1/2 on falling.
    function automatic logic sample_edge_rising(
        input logic cpol,
        input logic cpha
    );
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage synchroniser with a selectable reset level.
// Ports: i_clk, i_rst_n (sync, active low), i_d async in, o_q out.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_d};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_s_rx.sv
// SPI slave receiver: synchronises SCLK/CS_N/MOSI, deserialises
// MSB-first words, pulses o_rx_data_valid per word, o_rx_err on
// a partial-word frame end; o_rx_busy while the frame is active.
module spi_s_rx
    import spi_pkg::*;
#(
    parameter logic CPOL        = 1'b1,
    parameter logic CPHA        = 1'b0,
    parameter int   DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int   SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_spi_clk,
    input  logic                  i_spi_cs_n,
    input  logic                  i_spi_rx,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_data_valid,
    output logic                  o_rx_busy,
    output logic                  o_rx_err
);

    localparam int   CW   = $clog2(DATA_WIDTH);
    localparam logic RISE = sample_edge_rising(CPOL, CPHA);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_spi_clk),
        .o_q    (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_spi_cs_n),
        .o_q    (cs_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_spi_rx),
        .o_q    (mosi_s)
    );

    rx_state_e             state_q, state_d;
    logic                  sclk_prev_q, sclk_prev_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic                  sample;
    logic [DATA_WIDTH-1:0] word;

    assign sample = RISE ? (sclk_s & ~sclk_prev_q)
                         : (~sclk_s & sclk_prev_q);
    assign word   = {shift_q[DATA_WIDTH-2:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        sclk_prev_d = sclk_s;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!cs_s) begin
                    state_d = RX_RECV;
                end
            end
            RX_RECV: begin
                // Frame end takes priority over any coincident sample edge.
                if (cs_s) begin
                    state_d = RX_IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
                    err_d   = (cnt_q != '0);
                end else if (sample) begin
                    shift_d = word;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        data_d  = word;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= RX_IDLE;
            sclk_prev_q <= CPOL;
            shift_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign o_rx_data       = data_q;
    assign o_rx_data_valid = valid_q;
    assign o_rx_busy       = (state_q == RX_RECV);
    assign o_rx_err        = err_q;

endmodule

// File: tb/tb_spi_s_rx.sv
// Bench for spi_s_rx: one instance per SPI mode, driven by
// a bench SPI master model; table vectors plus corner sequences.
module tb_spi_s_rx;

    localparam int H = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sclk;
    logic       cs_n;
    logic       mosi;

    logic [7:0] data [4];
    logic [3:0] valid;
    logic [3:0] busy;
    logic [3:0] err;

    int         vcnt [4];
    int         ecnt [4];
    logic [7:0] q2 [$];

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam logic [1:0] M = 2'(g);
        spi_s_rx #(
            .CPOL       (M[1]),
            .CPHA       (M[0]),
            .DATA_WIDTH (8),
            .SYNC_STAGES(2)
        ) u_dut (
            .i_clk          (clk),
            .i_rst_n        (rst_n),
            .i_spi_clk      (sclk[g]),
            .i_spi_cs_n     (cs_n),
            .i_spi_rx       (mosi),
            .o_rx_data      (data[g]),
            .o_rx_data_valid(valid[g]),
            .o_rx_busy      (busy[g]),
            .o_rx_err       (err[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (valid[i]) vcnt[i] <= vcnt[i] + 1;
            if (err[i])   ecnt[i] <= ecnt[i] + 1;
        end
        if (valid[2]) q2.push_back(data[2]);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bits(input int m, input logic [15:0] bits,
                             input int n);
        logic [1:0] mm;
        mm = m[1:0];
        for (int i = n - 1; i >= 0; i--) begin
            if (!mm[0]) begin
                mosi = bits[i];
                wait_clks(H);
                sclk[m] = ~mm[1];
                wait_clks(H);
                sclk[m] = mm[1];
            end else begin
                sclk[m] = ~mm[1];
                mosi = bits[i];
                wait_clks(H);
                sclk[m] = mm[1];
                wait_clks(H);
            end
        end
    endtask

    task automatic send_frame(input int m, input logic [15:0] bits,
                              input int n);
        cs_n = 1'b0;
        wait_clks(H);
        send_bits(m, bits, n);
        wait_clks(H);
        cs_n = 1'b1;
        wait_clks(3 * H);
    endtask

    typedef struct {
        int          mode;
        logic [15:0] bits;
        int          nbits;
        logic [7:0]  exp_data;
        int          exp_valid;
        int          exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int v0, e0, m;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        sclk  = 4'b1100;
        cs_n  = 1'b1;
        mosi  = 1'b0;

        vecs[0] = '{2, 16'h00AD, 8, 8'hAD, 1, 0};
        vecs[1] = '{0, 16'h003C, 8, 8'h3C, 1, 0};
        vecs[2] = '{1, 16'h003C, 8, 8'h3C, 1, 0};
        vecs[3] = '{2, 16'h003C, 8, 8'h3C, 1, 0};
        vecs[4] = '{3, 16'h003C, 8, 8'h3C, 1, 0};
        vecs[5] = '{2, 16'h001F, 5, 8'h3C, 0, 1};
        vecs[6] = '{2, 16'h005A, 8, 8'h5A, 1, 0};
        vecs[7] = '{0, 16'h0005, 3, 8'h3C, 0, 1};

        wait_clks(3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst data m%0d", i), 32'(data[i]), 0);
            chk($sformatf("rst valid m%0d", i), 32'(valid[i]), 0);
            chk($sformatf("rst busy m%0d", i), 32'(busy[i]), 0);
            chk($sformatf("rst err m%0d", i), 32'(err[i]), 0);
        end
        rst_n = 1'b1;
        wait_clks(4);

        // Busy tracks the frame.
        cs_n = 1'b0;
        wait_clks(H);
        chk("busy in frame", 32'(busy[2]), 1);
        send_bits(2, 16'h00AD, 8);
        wait_clks(H);
        cs_n = 1'b1;
        wait_clks(3 * H);
        chk("busy after frame", 32'(busy[2]), 0);
        chk("loopback data", 32'(data[2]), 32'h00AD);

        for (int k = 0; k < 8; k++) begin
            m  = vecs[k].mode;
            v0 = vcnt[m];
            e0 = ecnt[m];
            send_frame(m, vecs[k].bits, vecs[k].nbits);
            chk($sformatf("v%0d data", k), 32'(data[m]),
                32'(vecs[k].exp_data));
            chk($sformatf("v%0d valid", k), 32'(vcnt[m] - v0),
                32'(vecs[k].exp_valid));
            chk($sformatf("v%0d err", k), 32'(ecnt[m] - e0),
                32'(vecs[k].exp_err));
            chk($sformatf("v%0d busy", k), 32'(busy[m]), 0);
        end

        // Two words back to back in one frame.
        q2.delete();
        e0 = ecnt[2];
        send_frame(2, 16'h1234, 16);
        chk("b2b count", 32'(q2.size()), 2);
        if (q2.size() == 2) begin
            chk("b2b word0", 32'(q2[0]), 32'h12);
            chk("b2b word1", 32'(q2[1]), 32'h34);
        end
        chk("b2b err", 32'(ecnt[2] - e0), 0);

        // Reset mid-frame after 3 bits.
        e0 = ecnt[2];
        cs_n = 1'b0;
        wait_clks(H);
        send_bits(2, 16'h0007, 3);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 4'b1100;
        wait_clks(2);
        chk("midrst data", 32'(data[2]), 0);
        chk("midrst valid", 32'(valid[2]), 0);
        chk("midrst busy", 32'(busy[2]), 0);
        chk("midrst err", 32'(err[2]), 0);
        rst_n = 1'b1;
        wait_clks(4);
        v0 = vcnt[2];
        send_frame(2, 16'h00C3, 8);
        chk("post rst data", 32'(data[2]), 32'hC3);
        chk("post rst valid", 32'(vcnt[2] - v0), 1);
        chk("post rst err", 32'(ecnt[2] - e0), 0);

        // SCLK toggling with CS_N high.
        v0 = vcnt[2];
        for (int i = 0; i < 16; i++) begin
            sclk[2] = ~sclk[2];
            wait_clks(H);
        end
        wait_clks(H);
        chk("idle toggle valid", 32'(vcnt[2] - v0), 0);
        chk("idle toggle busy", 32'(busy[2]), 0);
        chk("idle toggle data", 32'(data[2]), 32'hC3);
        send_frame(2, 16'h0001, 8);
        chk("after toggle data", 32'(data[2]), 32'h01);
        chk("after toggle valid", 32'(vcnt[2] - v0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
